// File: rtl/nco_phase_sweeper.sv
// NCO state sweeper: initialises the state RAM, then on each sample tick reads,
// advances and writes back every slot's phase while streaming it downstream.
module nco_phase_sweeper #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 8,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  output logic [V_WIDTH+O_WIDTH-1:0] ram_read_address,
  input  logic [50:0]                ram_q,
  output logic [V_WIDTH+O_WIDTH-1:0] ram_write_address,
  output logic [50:0]                ram_d,
  output logic                       ram_we,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [V_WIDTH-1:0]         upd_voice,
  input  logic [O_WIDTH-1:0]         upd_osc,
  input  logic [17:0]                upd_inc,
  input  logic                       upd_sync,
  input  logic                       upd_mute,
  output logic                       phase_valid,
  output logic [31:0]                phase_out,
  output logic [V_WIDTH-1:0]         phase_voice,
  output logic [O_WIDTH-1:0]         phase_osc,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ADDR_W = V_WIDTH + O_WIDTH;
  localparam int N      = VOICES * V_OSC;
  localparam int CNT_W  = ADDR_W + 2;
  localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_SWEEP = CNT_W'(N + 2);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SWEEP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              init_we;
  logic              vld_p0, vld_p1, vld_p2;
  logic [ADDR_W-1:0] addr_p0, addr_p1, addr_p2;

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [17:0]       pend_inc;
  logic              pend_sync, pend_mute;
  logic              upd_accept, pend_hit;

  logic              mute_p2;
  logic [17:0]       inc_p2;
  logic [31:0]       scaled_p2, out_phase_p2, new_phase_p2;

  // Pitch increment lands 8 bits up in the 32-bit accumulator.
  function automatic logic [31:0] scale_inc(input logic [17:0] inc);
    return {6'b0, inc, 8'b0};
  endfunction

  // Accumulator advance wraps modulo 2^32; no saturation by design.
  function automatic logic [31:0] phase_wrap_add(input logic [31:0] ph,
                                                 input logic [31:0] step);
    return ph + step;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    vld_p0    = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == N_CNT) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          init_we = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (sample_tick) begin
          state_nxt = S_SWEEP;
          cnt_nxt   = '0;
        end
      end
      S_SWEEP: begin
        // cnt keeps running past N to drain the two-cycle RAM read latency.
        vld_p0 = (cnt < N_CNT);
        if (cnt == LAST_SWEEP) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign busy             = (state != S_IDLE);
  assign addr_p0          = cnt[ADDR_W-1:0];
  assign ram_read_address = vld_p0 ? addr_p0 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (sample_tick && busy) overrun <= 1'b1;
  end

  // p0 -> p1 -> p2: address in flight while the RAM read completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= addr_p0;
    addr_p2 <= addr_p1;
  end

  assign upd_ready  = ~pend_vld;
  assign upd_accept = upd_valid & ~pend_vld;
  assign pend_hit   = vld_p2 & pend_vld & (pend_addr == addr_p2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_vld <= 1'b0;
    else if (pend_hit) pend_vld <= 1'b0;
    else if (upd_accept) pend_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (upd_accept) begin
      pend_addr <= {upd_voice, upd_osc};
      pend_inc  <= upd_inc;
      pend_sync <= upd_sync;
      pend_mute <= upd_mute;
    end
  end

  // p2: RAM word valid, merge pending update and advance phase
  always_comb begin
    mute_p2      = ram_q[50];
    inc_p2       = ram_q[49:32];
    out_phase_p2 = ram_q[31:0];
    if (pend_hit) begin
      mute_p2 = pend_mute;
      inc_p2  = pend_inc;
    end
    scaled_p2    = scale_inc(inc_p2);
    new_phase_p2 = phase_wrap_add(ram_q[31:0], scaled_p2);
    if (mute_p2) begin
      out_phase_p2 = '0;
      new_phase_p2 = '0;
    end else if (pend_hit && pend_sync) begin
      out_phase_p2 = '0;
      new_phase_p2 = scaled_p2;
    end
  end

  // p3: registered phase stream and RAM write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_valid       <= 1'b0;
      phase_out         <= '0;
      phase_voice       <= '0;
      phase_osc         <= '0;
      ram_we            <= 1'b0;
      ram_write_address <= '0;
      ram_d             <= '0;
    end else begin
      phase_valid <= vld_p2;
      ram_we      <= init_we | vld_p2;
      if (vld_p2) begin
        phase_out   <= out_phase_p2;
        phase_voice <= addr_p2[ADDR_W-1:O_WIDTH];
        phase_osc   <= addr_p2[O_WIDTH-1:0];
      end
      if (init_we) begin
        ram_write_address <= cnt[ADDR_W-1:0];
        ram_d             <= '0;
      end else if (vld_p2) begin
        ram_write_address <= addr_p2;
        ram_d             <= {mute_p2, inc_p2, new_phase_p2};
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_sweeper.sv
// Bench for nco_phase_sweeper: behavioural 2-cycle RAM, slot model feeding a
// scoreboard of expected phases, and scenario tasks.
module tb_nco_phase_sweeper;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [5:0]  ram_read_address, ram_write_address;
  logic [50:0] ram_q, ram_d;
  logic        ram_we;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [2:0]  upd_voice = '0, upd_osc = '0;
  logic [17:0] upd_inc = '0;
  logic        upd_sync = 1'b0, upd_mute = 1'b0;
  logic        phase_valid;
  logic [31:0] phase_out;
  logic [2:0]  phase_voice, phase_osc;
  logic        busy, overrun;

  nco_phase_sweeper dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .ram_read_address(ram_read_address), .ram_q(ram_q),
    .ram_write_address(ram_write_address), .ram_d(ram_d), .ram_we(ram_we),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_voice(upd_voice),
    .upd_osc(upd_osc), .upd_inc(upd_inc), .upd_sync(upd_sync), .upd_mute(upd_mute),
    .phase_valid(phase_valid), .phase_out(phase_out), .phase_voice(phase_voice),
    .phase_osc(phase_osc), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: registered address and registered output.
  logic [50:0] mem [N];
  logic [5:0]  rd_addr_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_address] <= ram_d;
    rd_addr_r <= ram_read_address;
    ram_q     <= mem[rd_addr_r];
  end

  typedef struct { int slot; logic [31:0] ph; } exp_t;
  exp_t        sb[$];
  logic [31:0] m_phase [N];
  logic [17:0] m_inc [N];
  logic        m_mute [N];
  logic [31:0] cap [N];
  bit          p_vld, p_sync, p_mute;
  int          p_addr;
  logic [17:0] p_inc;
  bit          mon_en = 0;
  int          total = 0, bad = 0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_phase[k] = '0; m_inc[k] = '0; m_mute[k] = 1'b0; cap[k] = '0;
    end
    p_vld = 0;
    sb.delete();
  endtask

  task automatic model_push_sweep();
    exp_t e;
    bit hit;
    logic mu;
    logic [17:0] in;
    logic [31:0] sc, o, nw;
    for (int k = 0; k < N; k++) begin
      hit = p_vld && (p_addr == k);
      mu  = hit ? p_mute : m_mute[k];
      in  = hit ? p_inc : m_inc[k];
      sc  = {6'b0, in, 8'b0};
      if (mu) begin
        o = '0; nw = '0;
      end else if (hit && p_sync) begin
        o = '0; nw = sc;
      end else begin
        o = m_phase[k]; nw = m_phase[k] + sc;
      end
      m_phase[k] = nw; m_inc[k] = in; m_mute[k] = mu;
      if (hit) p_vld = 0;
      e.slot = k; e.ph = o;
      sb.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    int s;
    forever begin
      @(negedge clk);
      if (mon_en && phase_valid) begin
        s = int'({phase_voice, phase_osc});
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_phase: slot=%0d phase=%h, required no output", s, phase_out);
        end else begin
          e = sb.pop_front();
          if (s !== e.slot || phase_out !== e.ph) begin
            bad++;
            $display("FAIL phase_stream: got slot=%0d phase=%h, required slot=%0d phase=%h",
                     s, phase_out, e.slot, e.ph);
          end
        end
        cap[s] = phase_out;
      end
    end
  endtask

  task automatic upd_send(input logic [5:0] a, input logic [17:0] inc, input logic s, input logic m);
    bit got = 0;
    upd_voice = a[5:3]; upd_osc = a[2:0]; upd_inc = inc; upd_sync = s; upd_mute = m;
    @(posedge clk); #1 upd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (upd_ready) begin got = 1; break; end
    end
    @(posedge clk); #1 upd_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL upd_handshake: upd_ready=%b, required 1 within 300 cycles", upd_ready);
    end else begin
      p_vld = 1; p_addr = int'(a); p_inc = inc; p_sync = s; p_mute = m;
    end
  endtask

  // One sweep; optional extra tick and a one-cycle update launched at given cycles.
  task automatic do_sweep(input int tick_at, input int upd_at);
    int pv_err = 0, busy_err = 0, ra_err = 0;
    model_push_sweep();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    for (int c = 0; c <= N + 5; c++) begin
      @(negedge clk);
      if (phase_valid !== (c >= 3 && c <= N + 2)) pv_err++;
      if (busy !== (c <= N + 2)) busy_err++;
      if (c < N && ram_read_address !== 6'(c)) ra_err++;
      if (tick_at >= 0 && c == tick_at) sample_tick = 1'b1;
      if (tick_at >= 0 && c == tick_at + 1) sample_tick = 1'b0;
      if (upd_at >= 0 && c == upd_at) upd_valid = 1'b1;
      if (upd_at >= 0 && c == upd_at + 1) begin
        upd_valid = 1'b0;
        total++;
        if (upd_ready !== 1'b0) begin
          bad++;
          $display("FAIL upd_accept_mid_sweep: upd_ready=%b, required 0", upd_ready);
        end
        p_vld = 1; p_addr = int'({upd_voice, upd_osc}); p_inc = upd_inc;
        p_sync = upd_sync; p_mute = upd_mute;
      end
    end
    total++;
    if (pv_err != 0) begin bad++; $display("FAIL phase_valid_window: bad_cycles=%0d, required 0", pv_err); end
    total++;
    if (busy_err != 0) begin bad++; $display("FAIL busy_window: bad_cycles=%0d, required 0", busy_err); end
    total++;
    if (ra_err != 0) begin bad++; $display("FAIL read_address_seq: bad_cycles=%0d, required 0", ra_err); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sweep_drain: left=%0d, required 0", sb.size()); end
  endtask

  task automatic test_reset();
    int nwe = 0, err = 0, last_c = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ram_we, phase_valid, busy, upd_ready, overrun} !== 5'b00110) begin
      bad++;
      $display("FAIL reset_ctrl: we,pv,busy,rdy,ovr=%b, required 00110",
               {ram_we, phase_valid, busy, upd_ready, overrun});
    end
    total++;
    if ({ram_d, phase_out, ram_read_address, ram_write_address, phase_voice, phase_osc} !== '0) begin
      bad++;
      $display("FAIL reset_data: ram_d=%h phase_out=%h ra=%0d wa=%0d, required all 0",
               ram_d, phase_out, ram_read_address, ram_write_address);
    end
    reset = 1'b0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (ram_we) begin
        if (ram_write_address !== 6'(nwe) || ram_d !== '0 || busy !== 1'b1) err++;
        if (nwe > 0 && c != last_c + 1) err++;
        last_c = c;
        nwe++;
      end
    end
    total++;
    if (nwe != N || err != 0) begin
      bad++;
      $display("FAIL init_writes: count=%0d errors=%0d, required count=64 errors=0", nwe, err);
    end
    total++;
    if (busy !== 1'b0 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL init_done: busy=%b ram_we=%b, required 0 0", busy, ram_we);
    end
    model_reset();
    mon_en = 1;
  endtask

  task automatic test_sync_update();
    int others;
    upd_send(6'd5, 18'd1, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      do_sweep(-1, -1);
      others = 0;
      for (int k = 0; k < N; k++) if (k != 5 && cap[k] !== '0) others++;
      total++;
      if (cap[5] !== 32'(j * 256)) begin
        bad++;
        $display("FAIL sync_slot5_sweep%0d: phase=%h, required %h", j, cap[5], 32'(j * 256));
      end
      total++;
      if (others != 0) begin bad++; $display("FAIL other_slots_zero: nonzero=%0d, required 0", others); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    upd_send(6'd63, 18'h3FFFF, 1'b1, 1'b0);
    for (int j = 1; j <= 66; j++) begin
      do_sweep(-1, -1);
      e = 32'(j - 1) * 32'h03FFFF00;
      total++;
      if (cap[63] !== e) begin bad++; $display("FAIL wrap_sweep%0d: phase=%h, required %h", j, cap[63], e); end
    end
    total++;
    if (cap[63] !== 32'h03FFBF00) begin
      bad++;
      $display("FAIL wrap_after: phase=%h, required 03ffbf00", cap[63]);
    end
  endtask

  task automatic test_mute();
    upd_send(6'd63, 18'h3FFFF, 1'b0, 1'b1);
    do_sweep(-1, -1);
    total++;
    if (cap[63] !== 32'h0) begin bad++; $display("FAIL mute_first: phase=%h, required 0", cap[63]); end
    do_sweep(-1, -1);
    total++;
    if (cap[63] !== 32'h0) begin bad++; $display("FAIL mute_hold: phase=%h, required 0", cap[63]); end
    upd_send(6'd63, 18'h3FFFF, 1'b0, 1'b0);
    do_sweep(-1, -1);
    do_sweep(-1, -1);
    total++;
    if (cap[63] !== 32'h03FFFF00) begin
      bad++;
      $display("FAIL unmute_restart: phase=%h, required 03ffff00", cap[63]);
    end
  endtask

  task automatic test_late_update();
    upd_voice = 3'd0; upd_osc = 3'd7; upd_inc = 18'd2; upd_sync = 1'b1; upd_mute = 1'b0;
    do_sweep(-1, 9);
    total++;
    if (upd_ready !== 1'b0) begin bad++; $display("FAIL late_ready_held: upd_ready=%b, required 0", upd_ready); end
    do_sweep(-1, -1);
    total++;
    if (cap[7] !== 32'h0) begin bad++; $display("FAIL late_applied_next: phase=%h, required 0", cap[7]); end
    total++;
    if (upd_ready !== 1'b1) begin bad++; $display("FAIL late_ready_back: upd_ready=%b, required 1", upd_ready); end
    do_sweep(-1, -1);
    total++;
    if (cap[7] !== 32'd512) begin bad++; $display("FAIL late_advance: phase=%h, required 200", cap[7]); end
  endtask

  task automatic test_overrun();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: overrun=%b, required 0", overrun); end
    do_sweep(N + 2, -1);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_at_end: overrun=%b, required 1", overrun); end
    do_sweep(20, -1);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: overrun=%b, required 1", overrun); end
  endtask

  task automatic test_reset_mid_sweep();
    int nwe = 0, err = 0, nz = 0, idle_err = 0;
    mon_en = 0;
    upd_voice = 3'd7; upd_osc = 3'd4; upd_inc = 18'd5; upd_sync = 1'b1; upd_mute = 1'b0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 25) upd_valid = 1'b1;
      if (c == 26) upd_valid = 1'b0;
    end
    total++;
    if (phase_valid !== 1'b1) begin bad++; $display("FAIL midsweep_active: phase_valid=%b, required 1", phase_valid); end
    reset = 1'b1;
    #1;
    total++;
    if ({ram_we, phase_valid, overrun, busy, upd_ready} !== 5'b00011) begin
      bad++;
      $display("FAIL async_reset: we,pv,ovr,busy,rdy=%b, required 00011",
               {ram_we, phase_valid, overrun, busy, upd_ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (c == 10) sample_tick = 1'b1;
      if (c == 11) sample_tick = 1'b0;
      if (ram_we) begin
        if (ram_write_address !== 6'(nwe) || ram_d !== '0) err++;
        nwe++;
      end
    end
    total++;
    if (nwe != N || err != 0) begin
      bad++;
      $display("FAIL reinit_writes: count=%0d errors=%0d, required count=64 errors=0", nwe, err);
    end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_in_init: overrun=%b, required 1", overrun); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (phase_valid !== 1'b0 || busy !== 1'b0) idle_err++;
    end
    total++;
    if (idle_err != 0) begin bad++; $display("FAIL no_sweep_after_init: bad_cycles=%0d, required 0", idle_err); end
    for (int k = 0; k < N; k++) if (mem[k] !== '0) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL ram_rezeroed: nonzero_words=%0d, required 0", nz); end
    model_reset();
    mon_en = 1;
    do_sweep(-1, -1);
    total++;
    if (cap[5] !== 32'h0) begin bad++; $display("FAIL slot5_cleared: phase=%h, required 0", cap[5]); end
    do_sweep(-1, -1);
    total++;
    if (cap[60] !== 32'h0) begin bad++; $display("FAIL pending_dropped: phase=%h, required 0", cap[60]); end
  endtask

  initial begin
    model_reset();
    fork
      monitor_loop();
    join_none
    test_reset();
    test_sync_update();
    test_wrap();
    test_mute();
    test_late_update();
    test_overrun();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_phase_sweeper.md
Name: nco_phase_sweeper

Overview:
- Sequencer that sits directly upstream of the dual-port NCO state RAM.
- On each sample tick it sweeps every voice/oscillator slot: it reads the 51-bit state word, advances the phase accumulator by the stored pitch increment, and writes the word back.
- It streams the current phase of each slot to the waveform stage.
- It merges host pitch, sync and mute updates into the sweep through a valid/ready port.

Parameters:
- VOICES, 8: number of voices.
- V_OSC, 8: oscillators per voice.
- V_WIDTH, 3: voice index width (log2 VOICES).
- O_WIDTH, 3: oscillator index width (log2 V_OSC).
- N (derived) = VOICES*V_OSC: slot count. Slot address = {voice, osc}.

Ports:
- clk  in  1: single clock for all logic. The RAM write and read clocks are tied to it.
- reset  in  1: asynchronous, active-high.
- sample_tick  in  1: one-cycle pulse that requests a sweep.
- ram_read_address  out  V_WIDTH+O_WIDTH: drives RAM port A read address.
- ram_q  in  51: RAM port A data. Valid 2 cycles after the address is presented.
- ram_write_address  out  V_WIDTH+O_WIDTH: RAM write address.
- ram_d  out  51: RAM write data. Fields: [50] mute, [49:32] inc, [31:0] phase.
- ram_we  out  1: RAM write enable.
- upd_valid  in  1: host update request.
- upd_ready  out  1: update accepted when upd_valid and upd_ready are both high.
- upd_voice  in  V_WIDTH: target voice of the update.
- upd_osc  in  O_WIDTH: target oscillator of the update.
- upd_inc  in  18: new pitch increment.
- upd_sync  in  1: zero the phase of the target slot.
- upd_mute  in  1: new mute bit.
- phase_valid  out  1: phase_out, phase_voice and phase_osc are valid this cycle.
- phase_out  out  32: current phase of the slot.
- phase_voice  out  V_WIDTH: voice index of phase_out.
- phase_osc  out  O_WIDTH: oscillator index of phase_out.
- busy  out  1: high in INIT and SWEEP.
- overrun  out  1: sticky. Set when sample_tick arrives while busy.

Behaviour:
- Reset values: every output is 0 except upd_ready, busy and overrun.
  - upd_ready = 1 and busy = 1.
  - overrun = 0.
  - The FSM enters INIT.
- INIT:
  - Writes ram_d = 0 with ram_we = 1 to addresses 0..N-1, one per cycle.
  - After address N-1 the FSM goes to IDLE and busy drops.
  - sample_tick is ignored in INIT and sets overrun.
- IDLE:
  - sample_tick goes to SWEEP. The read counter is 0 in the following cycle (T0).
  - busy stays high from T0 until the last write has been issued.
- SWEEP read side:
  - ram_read_address = k at cycle T0+k, for k = 0..N-1.
  - ram_q for slot k is valid at T0+k+2.
- SWEEP compute, combinational on ram_q:
  - scaled = {6'b0, inc, 8'b0}.
  - If mute = 1: the outgoing phase is 0 and the stored phase is 0.
  - Otherwise: the outgoing phase is the stored phase, and the new stored phase = phase + scaled, mod 2^32 (wraps naturally).
- SWEEP register stage, at T0+k+3:
  - phase_valid = 1 with phase_out, phase_voice and phase_osc for slot k.
  - ram_we = 1, ram_write_address = k, ram_d = updated word.
  - The RAM commits the write at T0+k+4.
- Sweep end:
  - The last output is at T0+N+2. The FSM returns to IDLE at T0+N+3 and busy deasserts.
  - Each address is accessed once per sweep, so no read-after-write hazard exists within a sweep.
- Update port:
  - On acceptance, the pending register latches {addr, inc, sync, mute} and upd_ready drops.
  - While a slot's word is being computed, if pending is valid and its address equals that slot:
    - inc and mute are replaced by the pending values.
    - If sync = 1, the outgoing phase is 0 and the stored phase = scaled (new inc). Mute overrides sync: stored phase is 0.
    - pending clears, and upd_ready rises the next cycle.
  - An update accepted in the same cycle that its slot is computed is not applied. It waits for the next sweep.
  - An update accepted after its slot has passed waits for the next sweep.
  - Updates are accepted in any state. In INIT they apply at the first sweep.
- sample_tick while busy: ignored and sets overrun, even when coincident with the IDLE transition cycle. A tick is accepted only when the FSM is in IDLE.
- Reset mid-sweep:
  - The FSM aborts to INIT, all RAM words are re-zeroed, and pending clears.
  - ram_we and phase_valid go low immediately (asynchronous).

Test Plan:
- Reset release -> busy high 64 cycles, ram_we high for exactly 64 cycles with ram_write_address 0..63 and ram_d = 0, then busy = 0.
- Update slot 5 (voice 0, osc 5) with inc = 1, sync = 1, mute = 0, then 3 ticks -> slot 5 phase_out = 0, 256, 512. Every other slot phase_out = 0. phase_valid is high for 64 consecutive cycles starting at T0+3.
- inc = 18'h3FFFF on slot 63, run until wrap -> phase advances by 0x03FFFF00 per sweep. It wraps mod 2^32 with no saturation and the phase after wrap is correct.
- Update with mute = 1 on an active slot -> phase_out = 0 from that sweep onward. Clearing mute with sync = 0 -> phase restarts from 0 + scaled.
- Update accepted at the cycle slot 7 is computed -> not applied in that sweep, applied in the next. upd_ready stays low until then.
- sample_tick during SWEEP and during INIT -> no extra sweep starts, overrun = 1. Assert reset mid-sweep -> overrun = 0, INIT re-zeroes all slots.
